// File: rtl/keyed_lut_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keyed_lut_pkg
// Description : Shared definitions for the keyed lookup-table pipeline:
//               default widths, the entry-index width function and the
//               packing order of a table entry, {vld, key, data} from MSB
//               down to LSB.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package keyed_lut_pkg;

  localparam int DEF_NR_KEY   = 4;
  localparam int DEF_KEY_LEN  = 4;
  localparam int DEF_DATA_LEN = 8;

  // Entry index width. A single-entry table still needs a 1-bit index.
  function automatic int idx_len(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // A packed entry is {vld, key, data}: data in the LSBs, key above it,
  // and the valid bit on top.
  function automatic int ent_len(input int key_len, input int data_len);
    return 1 + key_len + data_len;
  endfunction

  function automatic int ent_key_lsb(input int data_len);
    return data_len;
  endfunction

  function automatic int ent_vld_pos(input int key_len, input int data_len);
    return key_len + data_len;
  endfunction

endpackage : keyed_lut_pkg
`default_nettype wire

// File: rtl/keyed_lut_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : keyed_lut_pipe_if
// Description : Bundle for the keyed lookup-table pipeline. It carries the
//               table write port, the synchronous clear, the miss default
//               and the request/response valid/ready handshake.
//               The slave modport is the table. The master modport is the
//               user of the table.
// Ports       : write   - clr, wr_en, wr_idx, wr_key, wr_data, wr_vld
//               request - req_valid, req_ready, req_key, default_out
//               resp    - resp_valid, resp_ready, resp_hit, resp_idx,
//                         resp_data, resp_multi (only with the macro)
// Macro       : KEYED_LUT_MULTIHIT_EN adds the resp_multi signal.
// Revision    : 1.0 - initial release
// ============================================================================
interface keyed_lut_pipe_if #(
  parameter int NR_KEY   = keyed_lut_pkg::DEF_NR_KEY,
  parameter int KEY_LEN  = keyed_lut_pkg::DEF_KEY_LEN,
  parameter int DATA_LEN = keyed_lut_pkg::DEF_DATA_LEN
) ();
  localparam int IDX_LEN = keyed_lut_pkg::idx_len(NR_KEY);

  logic                clr;
  logic                wr_en;
  logic [IDX_LEN-1:0]  wr_idx;
  logic [KEY_LEN-1:0]  wr_key;
  logic [DATA_LEN-1:0] wr_data;
  logic                wr_vld;
  logic [DATA_LEN-1:0] default_out;
  logic                req_valid;
  logic                req_ready;
  logic [KEY_LEN-1:0]  req_key;
  logic                resp_valid;
  logic                resp_ready;
  logic                resp_hit;
  logic [IDX_LEN-1:0]  resp_idx;
  logic [DATA_LEN-1:0] resp_data;
`ifdef KEYED_LUT_MULTIHIT_EN
  logic                resp_multi;
`endif

  modport slave (
    input  clr, wr_en, wr_idx, wr_key, wr_data, wr_vld, default_out,
    input  req_valid, req_key, resp_ready,
`ifdef KEYED_LUT_MULTIHIT_EN
    output resp_multi,
`endif
    output req_ready, resp_valid, resp_hit, resp_idx, resp_data
  );

  modport master (
    output clr, wr_en, wr_idx, wr_key, wr_data, wr_vld, default_out,
    output req_valid, req_key, resp_ready,
`ifdef KEYED_LUT_MULTIHIT_EN
    input  resp_multi,
`endif
    input  req_ready, resp_valid, resp_hit, resp_idx, resp_data
  );

endinterface : keyed_lut_pipe_if
`default_nettype wire

// File: rtl/keyed_lut_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : keyed_lut_prio_enc
// Description : Priority encoder over a match vector. The lowest set bit
//               wins. It also flags when more than one bit is set.
// Ports       : match [N-1:0] in  - match vector
//               any           out - at least one bit set
//               idx           out - index of the lowest set bit (0 if none)
//               multi         out - more than one bit set
// Revision    : 1.0 - initial release
// ============================================================================
module keyed_lut_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0]                           match,
  output logic                                   any,
  output logic [keyed_lut_pkg::idx_len(N)-1:0]   idx,
  output logic                                   multi
);
  localparam int IW = keyed_lut_pkg::idx_len(N);

  // The loop scans downward, so the last assignment comes from the lowest
  // set bit.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (match[i]) idx = IW'(i);
    end
  end

  assign any   = |match;
  // Clearing the lowest set bit leaves a non-zero value only when a second
  // bit is set.
  assign multi = (match & (match - N'(1))) != '0;

endmodule : keyed_lut_prio_enc
`default_nettype wire

// File: rtl/keyed_lut_pipe.sv
`default_nettype none
// ============================================================================
// Module      : keyed_lut_pipe
// Description : Programmable key->data lookup table with one registered
//               valid/ready response stage. Each entry holds
//               {vld, key, data}. The lowest matching valid index supplies
//               the response. A lookup sees the table as it was before the
//               current clock edge.
// Ports       : clk   in - clock, rising edge
//               rst_n in - asynchronous active-low reset
//               bus   slave - write port, clear, request and response
//                             (see keyed_lut_pipe_if)
// Macro       : KEYED_LUT_MULTIHIT_EN registers the multi-hit flag and
//               drives it on bus.resp_multi.
// Revision    : 1.0 - initial release
// ============================================================================
module keyed_lut_pipe
  import keyed_lut_pkg::*;
#(
  parameter int NR_KEY      = DEF_NR_KEY,
  parameter int KEY_LEN     = DEF_KEY_LEN,
  parameter int DATA_LEN    = DEF_DATA_LEN,
  parameter int HAS_DEFAULT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  keyed_lut_pipe_if.slave  bus
);
  localparam int IDX_LEN = idx_len(NR_KEY);
  localparam int ENT_LEN = ent_len(KEY_LEN, DATA_LEN);
  localparam int VLD_POS = ent_vld_pos(KEY_LEN, DATA_LEN);
  localparam int KEY_LSB = ent_key_lsb(DATA_LEN);
  localparam int KD_LEN  = KEY_LEN + DATA_LEN;

  // ---------------- table storage ----------------
  // The valid bits are reset. The key/data payload is not, because a
  // cleared valid bit masks it.
  logic [NR_KEY-1:0] vld_q, vld_d;
  logic [KD_LEN-1:0] kd_q [NR_KEY];
  logic [KD_LEN-1:0] kd_d [NR_KEY];
  logic [ENT_LEN-1:0] wr_ent;
  logic               wr_ok;

  assign wr_ent = {bus.wr_vld, bus.wr_key, bus.wr_data};
  // An out-of-range index is ignored. This only matters when NR_KEY is not
  // a power of two.
  assign wr_ok  = bus.wr_en && (int'(bus.wr_idx) < NR_KEY);

  // The clear is applied first, then the write, so that a write in the same
  // cycle as clr wins for its own entry.
  always_comb begin
    vld_d = bus.clr ? '0 : vld_q;
    for (int i = 0; i < NR_KEY; i++) kd_d[i] = kd_q[i];
    if (wr_ok) begin
      vld_d[bus.wr_idx] = wr_ent[VLD_POS];
      kd_d[bus.wr_idx]  = wr_ent[KD_LEN-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    kd_q <= kd_d;
  end

  // ---------------- match and priority select ----------------
  logic [NR_KEY-1:0]   match;
  logic                hit;
  logic [IDX_LEN-1:0]  hit_idx;
  logic [DATA_LEN-1:0] sel_data;

  for (genvar i = 0; i < NR_KEY; i++) begin : g_match
    assign match[i] = vld_q[i] && (kd_q[i][KEY_LSB +: KEY_LEN] == bus.req_key);
  end

`ifdef KEYED_LUT_MULTIHIT_EN
  logic multi;
`else
  logic multi_unused;
`endif

  keyed_lut_prio_enc #(.N(NR_KEY)) u_prio_enc (
    .match (match),
    .any   (hit),
    .idx   (hit_idx),
`ifdef KEYED_LUT_MULTIHIT_EN
    .multi (multi)
`else
    .multi (multi_unused)
`endif
  );

  // On a miss the encoder returns index 0. The data read from entry 0 is
  // then replaced by the miss value below.
  assign sel_data = hit ? kd_q[hit_idx][DATA_LEN-1:0]
                        : ((HAS_DEFAULT != 0) ? bus.default_out : '0);

  // ---------------- response register ----------------
  logic                req_ready, accept;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_hit_q, resp_hit_d;
  logic [IDX_LEN-1:0]  resp_idx_q, resp_idx_d;
  logic [DATA_LEN-1:0] resp_data_q, resp_data_d;
`ifdef KEYED_LUT_MULTIHIT_EN
  logic                resp_multi_q, resp_multi_d;
`endif

  assign req_ready = !resp_valid_q || bus.resp_ready;
  assign accept    = bus.req_valid && req_ready;

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_hit_d   = resp_hit_q;
    resp_idx_d   = resp_idx_q;
    resp_data_d  = resp_data_q;
`ifdef KEYED_LUT_MULTIHIT_EN
    resp_multi_d = resp_multi_q;
`endif
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_hit_d   = hit;
      resp_idx_d   = hit_idx;
      resp_data_d  = sel_data;
`ifdef KEYED_LUT_MULTIHIT_EN
      resp_multi_d = multi;
`endif
    end else if (bus.resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_idx_q   <= '0;
      resp_data_q  <= '0;
`ifdef KEYED_LUT_MULTIHIT_EN
      resp_multi_q <= 1'b0;
`endif
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_idx_q   <= resp_idx_d;
      resp_data_q  <= resp_data_d;
`ifdef KEYED_LUT_MULTIHIT_EN
      resp_multi_q <= resp_multi_d;
`endif
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_idx   = resp_idx_q;
  assign bus.resp_data  = resp_data_q;
`ifdef KEYED_LUT_MULTIHIT_EN
  assign bus.resp_multi = resp_multi_q;
`endif

endmodule : keyed_lut_pipe
`default_nettype wire

// File: tb/tb_keyed_lut_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_keyed_lut_pipe
// Description : Self-checking bench for keyed_lut_pipe. A directed sequence
//               is followed by randomized traffic. Both are compared against
//               a behavioural table/response model kept in this module.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keyed_lut_pipe;
  localparam int NR_KEY      = 4;
  localparam int KEY_LEN     = 4;
  localparam int DATA_LEN    = 8;
  localparam int HAS_DEFAULT = 1;
  localparam int IDX_LEN     = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keyed_lut_pipe_if #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN)) bus ();

  keyed_lut_pipe #(
    .NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN), .HAS_DEFAULT(HAS_DEFAULT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: the table contents and the one pending response.
  logic                m_vld  [NR_KEY];
  logic [KEY_LEN-1:0]  m_key  [NR_KEY];
  logic [DATA_LEN-1:0] m_data [NR_KEY];
  logic                m_rv, m_hit, m_multi;
  logic [IDX_LEN-1:0]  m_idx;
  logic [DATA_LEN-1:0] m_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR_KEY; i++) m_vld[i] = 1'b0;
    m_rv = 1'b0; m_hit = 1'b0; m_idx = '0; m_dout = '0; m_multi = 1'b0;
  endtask

  task automatic idle();
    bus.clr = 1'b0; bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_key = '0;
    bus.wr_data = '0; bus.wr_vld = 1'b0; bus.req_valid = 1'b0;
    bus.req_key = '0; bus.resp_ready = 1'b1;
  endtask

  task automatic wr(input int idx, input int key, input int data, input logic vld);
    bus.wr_en = 1'b1; bus.wr_idx = IDX_LEN'(idx); bus.wr_key = KEY_LEN'(key);
    bus.wr_data = DATA_LEN'(data); bus.wr_vld = vld;
  endtask

  task automatic req(input int key);
    bus.req_valid = 1'b1; bus.req_key = KEY_LEN'(key);
  endtask

  // Advance one clock edge with the inputs currently applied. The model is
  // updated from the rules, then the DUT outputs are checked after the edge.
  task automatic step();
    int   first, cnt;
    logic acc;
    #1;
    check("req_ready", bus.req_ready, !m_rv || bus.resp_ready);
    acc = bus.req_valid && (!m_rv || bus.resp_ready);
    if (acc) begin
      first = -1; cnt = 0;
      for (int i = 0; i < NR_KEY; i++) begin
        if (m_vld[i] && m_key[i] == bus.req_key) begin
          cnt++;
          if (first < 0) first = i;
        end
      end
      m_rv    = 1'b1;
      m_hit   = (first >= 0);
      m_idx   = m_hit ? IDX_LEN'(first) : '0;
      m_dout  = m_hit ? m_data[first] : ((HAS_DEFAULT != 0) ? bus.default_out : '0);
      m_multi = (cnt > 1);
    end else if (bus.resp_ready) begin
      m_rv = 1'b0;
    end
    if (bus.clr) for (int i = 0; i < NR_KEY; i++) m_vld[i] = 1'b0;
    if (bus.wr_en && int'(bus.wr_idx) < NR_KEY) begin
      m_vld[bus.wr_idx]  = bus.wr_vld;
      m_key[bus.wr_idx]  = bus.wr_key;
      m_data[bus.wr_idx] = bus.wr_data;
    end
    @(posedge clk);
    #1;
    check("resp_valid", bus.resp_valid, m_rv);
    if (m_rv) begin
      check("resp_hit", bus.resp_hit, m_hit);
      check("resp_idx", bus.resp_idx, m_idx);
      check("resp_data", bus.resp_data, m_dout);
`ifdef KEYED_LUT_MULTIHIT_EN
      check("resp_multi", bus.resp_multi, m_multi);
`endif
    end
  endtask

  initial begin
    idle();
    bus.default_out = 8'hEE;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus.resp_valid, 1'b0);
    check("rst_hit", bus.resp_hit, 1'b0);
    check("rst_idx", bus.resp_idx, 0);
    check("rst_data", bus.resp_data, 0);
    check("rst_ready", bus.req_ready, 1'b1);
    rst_n = 1'b1;

    // 1: miss after reset returns default_out
    req(3); step();
    check("t1_data", bus.resp_data, 8'hEE);
    check("t1_hit", bus.resp_hit, 1'b0);

    // 2: write then look up the following cycle
    idle(); wr(1, 3, 8'hA5, 1'b1); step();
    idle(); req(3); step();
    check("t2_hit", bus.resp_hit, 1'b1);
    check("t2_idx", bus.resp_idx, 1);
    check("t2_data", bus.resp_data, 8'hA5);

    // 3: multi-hit, the lowest index wins
    idle(); wr(0, 3, 8'h11, 1'b1); step();
    idle(); wr(2, 3, 8'h22, 1'b1); step();
    idle(); req(3); step();
    check("t3_idx", bus.resp_idx, 0);
    check("t3_data", bus.resp_data, 8'h11);

    // 4: a lookup in the same cycle as the write sees the old contents
    idle(); wr(2, 7, 8'h5A, 1'b1); req(7); step();
    check("t4_miss", bus.resp_hit, 1'b0);
    idle(); req(7); step();
    check("t4_hit", bus.resp_hit, 1'b1);
    check("t4_data", bus.resp_data, 8'h5A);

    // 5: stall for three cycles, then back-to-back accepts
    idle(); req(3); bus.resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_stall_data", bus.resp_data, 8'h5A);
    end
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req((i % 2 == 0) ? 3 : 7); step();
    end

    // 6: clr invalidates, then an async reset drops the pending response
    idle(); bus.clr = 1'b1; step();
    idle(); req(3); step();
    check("t6_clr_miss", bus.resp_hit, 1'b0);
    idle(); bus.resp_ready = 1'b0; step();
    #2; rst_n = 1'b0; #1;
    check("t6_arst_valid", bus.resp_valid, 1'b0);
    check("t6_arst_data", bus.resp_data, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(); step();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      idle();
      bus.req_valid   = ($urandom_range(0, 9) < 7);
      bus.req_key     = KEY_LEN'($urandom_range(0, 3));
      bus.resp_ready  = ($urandom_range(0, 9) < 7);
      bus.default_out = DATA_LEN'($urandom);
      bus.clr         = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 9) < 4)
        wr($urandom_range(0, 3), $urandom_range(0, 3), $urandom, ($urandom_range(0, 9) < 8));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule : tb_keyed_lut_pipe
`default_nettype wire
